inst_issue_queue: RTL and testbench

Parametrised instruction buffer and dual-issue pairing stage between fetch and decode. Accepts up to PUSH_WIDTH instructions per cycle from fetch into a DEPTH-entry circular queue. Each cycle it presents up to two head instructions to the two decoder lanes. Pre-decode pairing rules decide whether the second lane may issue: single-issue classes, RAW hazards, and branch/delay-slot binding.

---
 rtl/inst_issue_queue.sv | 173 +++++++++++++++++
 tb/tb_inst_issue_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_issue_queue.sv
// Instruction buffer between fetch and decode with a dual-issue pairing stage.
// Fetch pushes up to PUSH_WIDTH instructions per cycle; decode takes up to two per cycle.
module inst_issue_queue #(
  parameter int DEPTH      = 16,
  parameter int PUSH_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    dual_en,
  input  logic [PUSH_WIDTH-1:0]   push_valid,
  input  logic [32*PUSH_WIDTH-1:0] push_inst,
  input  logic [32*PUSH_WIDTH-1:0] push_pc,
  output logic                    push_ready,
  input  logic                    issue_ready,
  output logic                    slot0_valid,
  output logic                    slot1_valid,
  output logic [31:0]             slot0_inst,
  output logic [31:0]             slot1_inst,
  output logic [31:0]             slot0_pc,
  output logic [31:0]             slot1_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nx1;
  logic [CW-1:0] count_q;

  logic [CW-1:0] push_cnt;
  logic [CW-1:0] push_amt;
  logic [CW-1:0] issue_cnt;

  logic [31:0]   head_inst;
  logic [31:0]   next_inst;
  logic          head_one;
  logic          next_one;
  logic          head_br;
  logic          next_br;
  logic [4:0]    head_dest;
  logic [4:0]    next_rs;
  logic [4:0]    next_rt;
  logic          raw_hazard;
  logic          hold;

  // Single-issue classes: memory ops, COP0, HI/LO multiply-divide and SPECIAL2 MAC-style ops.
  function automatic logic is_one(input logic [31:0] inst);
    logic [5:0] op;
    logic [5:0] funct;
    op    = inst[31:26];
    funct = inst[5:0];
    is_one = ((op >= 6'h20) && (op <= 6'h26)) || (op == 6'h30) ||
             (op inside {6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E}) ||
             (op == 6'h10) ||
             ((op == 6'h00) && (funct >= 6'h18) && (funct <= 6'h1B)) ||
             ((op == 6'h1C) && (funct inside {6'h00, 6'h01, 6'h02, 6'h04, 6'h05}));
  endfunction

  function automatic logic is_br(input logic [31:0] inst);
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] funct;
    op    = inst[31:26];
    rt    = inst[20:16];
    funct = inst[5:0];
    is_br = ((op >= 6'h02) && (op <= 6'h07)) ||
            ((op == 6'h01) && (rt inside {5'h00, 5'h01, 5'h10, 5'h11})) ||
            ((op == 6'h00) && (funct inside {6'h08, 6'h09}));
  endfunction

  // Destination register written by an instruction; 0 means none (or $zero).
  function automatic logic [4:0] dest_reg(input logic [31:0] inst);
    logic [5:0] op;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
    op    = inst[31:26];
    rt    = inst[20:16];
    rd    = inst[15:11];
    funct = inst[5:0];
    dest_reg = 5'd0;
    case (op)
      6'h00: begin
        if (!((funct inside {6'h08, 6'h0C, 6'h0D, 6'h11, 6'h13}) ||
              ((funct >= 6'h18) && (funct <= 6'h1B)) ||
              ((funct >= 6'h30) && (funct <= 6'h36))))
          dest_reg = rd;
      end
      6'h1C: begin
        if (funct inside {6'h02, 6'h20, 6'h21})
          dest_reg = rd;
      end
      6'h03: dest_reg = 5'd31;
      6'h01: begin
        if (rt inside {5'h10, 5'h11})
          dest_reg = 5'd31;
      end
      default: begin
        if (((op >= 6'h08) && (op <= 6'h0F)) ||
            ((op >= 6'h20) && (op <= 6'h26)) || (op == 6'h30))
          dest_reg = rt;
      end
    endcase
  endfunction

  assign rd_ptr_nx1 = rd_ptr + AW'(1);
  assign head_inst  = inst_mem[rd_ptr];
  assign next_inst  = inst_mem[rd_ptr_nx1];

  assign head_one   = is_one(head_inst);
  assign next_one   = is_one(next_inst);
  assign head_br    = is_br(head_inst);
  assign next_br    = is_br(next_inst);
  assign head_dest  = dest_reg(head_inst);
  assign next_rs    = next_inst[25:21];
  assign next_rt    = next_inst[20:16];
  assign raw_hazard = (head_dest != 5'd0) &&
                      ((head_dest == next_rs) || (head_dest == next_rt));

  // A branch at the head waits until its delay slot has arrived so both can pair.
  assign hold = dual_en && head_br && (count_q < CW'(2));

  assign slot0_valid = (count_q >= CW'(1)) && !hold;
  assign slot1_valid = dual_en && (count_q >= CW'(2)) && !hold &&
                       !head_one && !next_one && !next_br && !raw_hazard;

  assign slot0_inst = head_inst;
  assign slot1_inst = next_inst;
  assign slot0_pc   = pc_mem[rd_ptr];
  assign slot1_pc   = pc_mem[rd_ptr_nx1];

  assign push_ready = ((CW'(DEPTH) - count_q) >= CW'(PUSH_WIDTH));
  assign count      = count_q;

  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < PUSH_WIDTH; i++)
      push_cnt = push_cnt + CW'(push_valid[i]);
  end

  assign push_amt  = push_ready ? push_cnt : '0;
  assign issue_cnt = issue_ready ? (CW'(slot0_valid) + CW'(slot1_valid)) : '0;

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ready) begin
      for (int i = 0; i < PUSH_WIDTH; i++) begin
        if (push_valid[i]) begin
          inst_mem[wr_ptr + AW'(i)] <= push_inst[32*i +: 32];
          pc_mem[wr_ptr + AW'(i)]   <= push_pc[32*i +: 32];
        end
      end
    end
  end

  // Reset and flush both empty the queue and suppress any issue on that edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + push_amt[AW-1:0];
      rd_ptr  <= rd_ptr + issue_cnt[AW-1:0];
      count_q <= count_q + push_amt - issue_cnt;
    end
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed testbench for inst_issue_queue (DEPTH=16, PUSH_WIDTH=2).
// Expected values are hand-derived from the pairing rules and pointer arithmetic.
module tb_inst_issue_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        dual_en;
  logic [1:0]  push_valid;
  logic [63:0] push_inst;
  logic [63:0] push_pc;
  logic        push_ready;
  logic        issue_ready;
  logic        slot0_valid;
  logic        slot1_valid;
  logic [31:0] slot0_inst;
  logic [31:0] slot1_inst;
  logic [31:0] slot0_pc;
  logic [31:0] slot1_pc;
  logic [4:0]  count;

  int checkCount;
  int passCount;

  logic [31:0] fillInst [16];
  logic [31:0] fillPc   [16];

  logic [31:0] addu3, or5, addu0, orZero, lw4, addu6, mtc0, mult, beq, addiu, wrapA, wrapB;

  inst_issue_queue #(.DEPTH(16), .PUSH_WIDTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .dual_en(dual_en),
    .push_valid(push_valid),
    .push_inst(push_inst),
    .push_pc(push_pc),
    .push_ready(push_ready),
    .issue_ready(issue_ready),
    .slot0_valid(slot0_valid),
    .slot1_valid(slot1_valid),
    .slot0_inst(slot0_inst),
    .slot1_inst(slot1_inst),
    .slot0_pc(slot0_pc),
    .slot1_pc(slot1_pc),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    rType = {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    iType = {op, rs, rt, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Hold one set of inputs across a single rising edge, then return to idle.
  task automatic applyStimulus(input logic [1:0] pv, input logic [31:0] i0, input logic [31:0] p0,
                               input logic [31:0] i1, input logic [31:0] p1,
                               input logic ir, input logic fl, input logic rs);
    push_valid  = pv;
    push_inst   = {i1, i0};
    push_pc     = {p1, p0};
    issue_ready = ir;
    flush       = fl;
    rst         = rs;
    @(posedge clk);
    #1;
    push_valid  = 2'b00;
    issue_ready = 1'b0;
    flush       = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic issueCycle();
    applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pushPair(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pcBase);
    applyStimulus(2'b11, i0, pcBase, i1, pcBase + 32'd4, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount  = 0;
    passCount   = 0;
    dual_en     = 1'b1;
    push_valid  = 2'b00;
    push_inst   = '0;
    push_pc     = '0;
    issue_ready = 1'b0;
    flush       = 1'b0;
    rst         = 1'b1;

    for (int k = 0; k < 16; k++) begin
      fillInst[k] = rType(5'd1, 5'd2, 5'(16 + k), 6'h21);
      fillPc[k]   = 32'h1000 + 32'(4 * k);
    end
    addu3  = rType(5'd1, 5'd2, 5'd3, 6'h21);
    or5    = rType(5'd3, 5'd4, 5'd5, 6'h25);
    addu0  = rType(5'd1, 5'd2, 5'd0, 6'h21);
    orZero = rType(5'd0, 5'd4, 5'd5, 6'h25);
    lw4    = iType(6'h23, 5'd1, 5'd4, 16'd0);
    addu6  = rType(5'd1, 5'd2, 5'd6, 6'h21);
    mtc0   = {6'h10, 5'd4, 5'd7, 5'd12, 11'd0};
    mult   = rType(5'd1, 5'd2, 5'd0, 6'h18);
    beq    = iType(6'h04, 5'd1, 5'd2, 16'd4);
    addiu  = iType(6'h09, 5'd1, 5'd8, 16'd5);
    wrapA  = rType(5'd9, 5'd10, 5'd20, 6'h21);
    wrapB  = rType(5'd11, 5'd12, 5'd21, 6'h21);

    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_count", 64'(count), 64'd0);
    checkOutput("reset_push_ready", 64'(push_ready), 64'd1);
    checkOutput("reset_slot0_valid", 64'(slot0_valid), 64'd0);
    checkOutput("reset_slot1_valid", 64'(slot1_valid), 64'd0);

    // Fill to full with issue held off, then drain two per cycle.
    for (int k = 0; k < 8; k++) begin
      pushPair(fillInst[2*k], fillInst[2*k+1], fillPc[2*k]);
      if (k == 6) begin
        checkOutput("fill_count14", 64'(count), 64'd14);
        checkOutput("fill_ready14", 64'(push_ready), 64'd1);
      end
    end
    checkOutput("full_count", 64'(count), 64'd16);
    checkOutput("full_push_ready", 64'(push_ready), 64'd0);
    pushPair(addu3, or5, 32'h9000);
    checkOutput("full_ignored_count", 64'(count), 64'd16);
    checkOutput("full_slot0_inst", 64'(slot0_inst), 64'(fillInst[0]));
    checkOutput("full_slot0_pc", 64'(slot0_pc), 64'(fillPc[0]));
    checkOutput("full_slot1_inst", 64'(slot1_inst), 64'(fillInst[1]));
    for (int j = 0; j < 8; j++) begin
      checkOutput("drain_slot0_inst", 64'(slot0_inst), 64'(fillInst[2*j]));
      checkOutput("drain_slot1_inst", 64'(slot1_inst), 64'(fillInst[2*j+1]));
      checkOutput("drain_slot1_pc", 64'(slot1_pc), 64'(fillPc[2*j+1]));
      checkOutput("drain_slot1_valid", 64'(slot1_valid), 64'd1);
      issueCycle();
    end
    checkOutput("drain_count", 64'(count), 64'd0);
    checkOutput("drain_slot0_valid", 64'(slot0_valid), 64'd0);

    // RAW hazard splits the pair; a $zero destination does not.
    pushPair(addu3, or5, 32'h2000);
    checkOutput("raw_slot0_valid", 64'(slot0_valid), 64'd1);
    checkOutput("raw_slot1_valid", 64'(slot1_valid), 64'd0);
    issueCycle();
    checkOutput("raw_count_after", 64'(count), 64'd1);
    checkOutput("raw_second_inst", 64'(slot0_inst), 64'(or5));
    checkOutput("raw_second_pc", 64'(slot0_pc), 64'h2004);
    issueCycle();
    pushPair(addu0, orZero, 32'h2100);
    checkOutput("zero_dest_pair", 64'(slot1_valid), 64'd1);
    issueCycle();
    checkOutput("zero_dest_count", 64'(count), 64'd0);

    // Single-issue classes in either slot.
    pushPair(lw4, addu6, 32'h3000);
    checkOutput("lw_slot1_valid", 64'(slot1_valid), 64'd0);
    issueCycle();
    checkOutput("lw_then_addu", 64'(slot0_inst), 64'(addu6));
    issueCycle();
    pushPair(addu6, mtc0, 32'h3100);
    checkOutput("mtc0_slot1_valid", 64'(slot1_valid), 64'd0);
    issueCycle();
    checkOutput("mtc0_next_inst", 64'(slot0_inst), 64'(mtc0));
    checkOutput("mtc0_next_valid", 64'(slot0_valid), 64'd1);
    issueCycle();
    pushPair(mult, addu6, 32'h3200);
    checkOutput("mult_head_pair", 64'(slot1_valid), 64'd0);
    issueCycle();
    issueCycle();
    pushPair(addu6, mult, 32'h3300);
    checkOutput("mult_second_pair", 64'(slot1_valid), 64'd0);
    issueCycle();
    issueCycle();
    checkOutput("class_count", 64'(count), 64'd0);

    // Branch waits for its delay slot when dual issue is on.
    applyStimulus(2'b01, beq, 32'h4000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("br_hold_count", 64'(count), 64'd1);
    checkOutput("br_hold_slot0", 64'(slot0_valid), 64'd0);
    applyStimulus(2'b01, addiu, 32'h4004, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("br_pair_count", 64'(count), 64'd2);
    checkOutput("br_pair_slot0", 64'(slot0_valid), 64'd1);
    checkOutput("br_pair_slot1", 64'(slot1_valid), 64'd1);
    checkOutput("br_pair_slot1_inst", 64'(slot1_inst), 64'(addiu));
    issueCycle();
    dual_en = 1'b0;
    applyStimulus(2'b01, beq, 32'h4100, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("br_single_slot0", 64'(slot0_valid), 64'd1);
    checkOutput("br_single_slot1", 64'(slot1_valid), 64'd0);
    issueCycle();
    checkOutput("br_single_count", 64'(count), 64'd0);
    dual_en = 1'b1;

    // Pointers now sit at 15: the next pair straddles the wrap point.
    pushPair(wrapA, wrapB, 32'h5000);
    checkOutput("wrap_slot0_inst", 64'(slot0_inst), 64'(wrapA));
    checkOutput("wrap_slot1_inst", 64'(slot1_inst), 64'(wrapB));
    checkOutput("wrap_slot1_pc", 64'(slot1_pc), 64'h5004);
    checkOutput("wrap_slot1_valid", 64'(slot1_valid), 64'd1);
    issueCycle();
    checkOutput("wrap_count", 64'(count), 64'd0);

    // Simultaneous push and issue at 14 entries and at full.
    for (int k = 0; k < 7; k++)
      pushPair(fillInst[2*k], fillInst[2*k+1], fillPc[2*k]);
    checkOutput("sim14_pre_count", 64'(count), 64'd14);
    applyStimulus(2'b11, fillInst[14], fillPc[14], fillInst[15], fillPc[15], 1'b1, 1'b0, 1'b0);
    checkOutput("sim14_count", 64'(count), 64'd14);
    checkOutput("sim14_head", 64'(slot0_inst), 64'(fillInst[2]));
    pushPair(fillInst[0], fillInst[1], fillPc[0]);
    checkOutput("sim16_count", 64'(count), 64'd16);
    applyStimulus(2'b11, addu3, 32'h9000, or5, 32'h9004, 1'b1, 1'b0, 1'b0);
    checkOutput("simfull_count", 64'(count), 64'd14);
    checkOutput("simfull_head", 64'(slot0_inst), 64'(fillInst[4]));

    // Flush and reset with a concurrent push and issue.
    applyStimulus(2'b11, addu3, 32'h6000, or5, 32'h6004, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_slot0_valid", 64'(slot0_valid), 64'd0);
    checkOutput("flush_push_ready", 64'(push_ready), 64'd1);
    applyStimulus(2'b01, addiu, 32'h6100, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_flush_count", 64'(count), 64'd1);
    checkOutput("post_flush_inst", 64'(slot0_inst), 64'(addiu));
    checkOutput("post_flush_pc", 64'(slot0_pc), 64'h6100);
    applyStimulus(2'b11, addu3, 32'h7000, or5, 32'h7004, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_slot0_valid", 64'(slot0_valid), 64'd0);
    checkOutput("rst_slot1_valid", 64'(slot1_valid), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
